lcd_spi_rx: RTL

LCD_SPI_RX -- requirements
Module: lcd_spi_rx

---
 rtl/lcd_pkg.sv | 22 ++
 rtl/lcd_spi_rx_shift.sv | 84 ++++++++
 rtl/lcd_spi_rx.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD SPI receiver.
//   COORD_W      coordinate width (9 bits, panels up to 512 pixels)
//   CMD_*        display command codes recognised by the decoder
//   dec_state_t  decoder state encoding
package lcd_pkg;

  localparam int COORD_W = 9;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CASET = 2'd1,
    ST_RASET = 2'd2,
    ST_RAMWR = 2'd3
  } dec_state_t;

endpackage

// File: rtl/lcd_spi_rx_shift.sv
// lcd_spi_rx_shift: synchroniser plus byte deserialiser for the LCD SPI link.
// Ports:
//   sys_clk_50MHz, sys_rst_n  system clock, async active-low reset
//   cs, dc, sclk, mosi        raw SPI pins (asynchronous to sys_clk_50MHz)
//   rx_data, rx_valid         registered word {dc, byte} and its strobe
//   rx_err                    strobe: cs rose with a partial byte pending
//   byte_done, byte_word      same-cycle precursor of rx_valid/rx_data, so
//                             downstream registers can update together
//                             with rx_valid
//   cs_rise                   synchronised cs rising edge
module lcd_spi_rx_shift (
  input  logic       sys_clk_50MHz,
  input  logic       sys_rst_n,
  input  logic       cs,
  input  logic       dc,
  input  logic       sclk,
  input  logic       mosi,
  output logic [8:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       byte_done,
  output logic [8:0] byte_word,
  output logic       cs_rise
);

  logic [1:0] cs_sync, dc_sync, sclk_sync, mosi_sync;
  logic       cs_d, sclk_d;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic       cs_active, sclk_rise, err_now;

  // cs synchroniser resets high (deselected) so release of reset never
  // looks like a cs edge.
  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cs_sync   <= 2'b11;
      dc_sync   <= 2'b00;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], cs};
      dc_sync   <= {dc_sync[0], dc};
      sclk_sync <= {sclk_sync[0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
      cs_d      <= cs_sync[1];
      sclk_d    <= sclk_sync[1];
    end
  end

  always_comb begin
    cs_active = ~cs_sync[1];
    sclk_rise = sclk_sync[1] & ~sclk_d;
    cs_rise   = cs_sync[1] & ~cs_d;
    byte_done = cs_active & sclk_rise & (bit_cnt == 3'd7);
    byte_word = {dc_sync[1], shreg, mosi_sync[1]};
    err_now   = cs_rise & (bit_cnt != 3'd0);
  end

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt  <= 3'd0;
      shreg    <= 7'd0;
      rx_data  <= 9'd0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= byte_done;
      rx_err   <= err_now;
      if (byte_done) begin
        rx_data <= byte_word;
      end
      if (!cs_active) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        // 3-bit counter wraps to 0 on the 8th bit
        shreg   <= {shreg[5:0], mosi_sync[1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: LCD SPI receiver with optional command/pixel decoder.
// Build option: define LCD_SPI_RX_CMD_DECODE_EN to build the CASET/RASET/RAMWR
// decoder; otherwise only the deserialiser exists and pix_* are tied to 0.
// Ports:
//   sys_clk_50MHz, sys_rst_n  system clock, async active-low reset
//   cs, dc, sclk, mosi        SPI pins
//   rx_data, rx_valid, rx_err received word {dc, byte}, strobes
//   pix_x, pix_y, pix_data    address and RGB565 value of an emitted pixel
//   pix_valid                 one-cycle pixel strobe (same cycle as rx_valid)
//
// Decoder states:
//   state    | meaning
//   ST_IDLE  | no active command; data bytes ignored
//   ST_CASET | collecting 4 column-window bytes
//   ST_RASET | collecting 4 row-window bytes
//   ST_RAMWR | pairing bytes into pixels, advancing address
module lcd_spi_rx
  import lcd_pkg::*;
#(
  parameter int H_RES = 240,
  parameter int V_RES = 240
) (
  input  logic         sys_clk_50MHz,
  input  logic         sys_rst_n,
  input  logic         cs,
  input  logic         dc,
  input  logic         sclk,
  input  logic         mosi,
  output logic [8:0]   rx_data,
  output logic         rx_valid,
  output logic         rx_err,
  output logic [8:0]   pix_x,
  output logic [8:0]   pix_y,
  output logic [15:0]  pix_data,
  output logic         pix_valid
);

  logic       byte_done;
  logic [8:0] byte_word;
  logic       cs_rise;

  lcd_spi_rx_shift u_shift (
    .sys_clk_50MHz (sys_clk_50MHz),
    .sys_rst_n     (sys_rst_n),
    .cs            (cs),
    .dc            (dc),
    .sclk          (sclk),
    .mosi          (mosi),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_err        (rx_err),
    .byte_done     (byte_done),
    .byte_word     (byte_word),
    .cs_rise       (cs_rise)
  );

`ifdef LCD_SPI_RX_CMD_DECODE_EN

  dec_state_t state_q, state_d;
  coord_t     x_start, x_end, y_start, y_end;
  coord_t     cur_x, cur_y;
  coord_t     win_start_tmp;
  logic       win_end_hi;
  logic [1:0] win_idx;
  logic       pix_phase;
  logic [7:0] pix_hi;
  logic       is_data;
  logic [7:0] rx_byte;

  assign is_data = byte_word[8];
  assign rx_byte = byte_word[7:0];

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (byte_done) begin
      if (!is_data) begin
        case (rx_byte)
          CMD_CASET: state_d = ST_CASET;
          CMD_RASET: state_d = ST_RASET;
          CMD_RAMWR: state_d = ST_RAMWR;
          default:   state_d = ST_IDLE;
        endcase
      end else if ((state_q == ST_CASET || state_q == ST_RASET) &&
                   win_idx == 2'd3) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x_start       <= '0;
      x_end         <= coord_t'(H_RES - 1);
      y_start       <= '0;
      y_end         <= coord_t'(V_RES - 1);
      cur_x         <= '0;
      cur_y         <= '0;
      win_start_tmp <= '0;
      win_end_hi    <= 1'b0;
      win_idx       <= 2'd0;
      pix_phase     <= 1'b0;
      pix_hi        <= 8'd0;
      pix_x         <= '0;
      pix_y         <= '0;
      pix_data      <= 16'd0;
      pix_valid     <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      if (byte_done) begin
        if (!is_data) begin
          // any command aborts a window load or a half-received pixel
          win_idx   <= 2'd0;
          pix_phase <= 1'b0;
          if (rx_byte == CMD_RAMWR) begin
            cur_x <= x_start;
            cur_y <= y_start;
            pix_x <= x_start;
            pix_y <= y_start;
          end
        end else begin
          case (state_q)
            ST_CASET, ST_RASET: begin
              win_idx <= win_idx + 2'd1;
              case (win_idx)
                2'd0: win_start_tmp[8]   <= rx_byte[0];
                2'd1: win_start_tmp[7:0] <= rx_byte;
                2'd2: win_end_hi         <= rx_byte[0];
                default: begin
                  // start and end commit together on the last byte
                  if (state_q == ST_CASET) begin
                    x_start <= win_start_tmp;
                    x_end   <= {win_end_hi, rx_byte};
                  end else begin
                    y_start <= win_start_tmp;
                    y_end   <= {win_end_hi, rx_byte};
                  end
                end
              endcase
            end
            ST_RAMWR: begin
              if (!pix_phase) begin
                pix_hi    <= rx_byte;
                pix_phase <= 1'b1;
              end else begin
                pix_phase <= 1'b0;
                pix_data  <= {pix_hi, rx_byte};
                pix_x     <= cur_x;
                pix_y     <= cur_y;
                pix_valid <= 1'b1;
                // counters wrap mod 512 so a start > end window still
                // reaches end eventually
                if (cur_x == x_end) begin
                  cur_x <= x_start;
                  cur_y <= (cur_y == y_end) ? y_start : cur_y + 9'd1;
                end else begin
                  cur_x <= cur_x + 9'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end else if (cs_rise) begin
        pix_phase <= 1'b0;
      end
    end
  end

`else

  logic decode_unused;
  assign decode_unused = ^{byte_done, byte_word, cs_rise,
                           9'(H_RES), 9'(V_RES)};

  assign pix_x     = '0;
  assign pix_y     = '0;
  assign pix_data  = '0;
  assign pix_valid = 1'b0;

`endif

endmodule
